// File: rtl/addsub_issuer.sv
// ---------------------------------------------------------------------------
// addsub_issuer
//
// Initiator-side controller for the addsub floating-point unit. It takes one
// add/subtract request at a time over a valid/ready handshake. It pulses
// add_start with registered operands and waits for add_done. It then returns
// the captured result over a valid/ready response channel. A watchdog ends the
// wait after TIMEOUT_CYCLES cycles so a hung addsub cannot stall the upstream.
//
// Optional feature (macro FP_NAN_BYPASS_EN):
//   When defined, a request with a NaN operand is answered directly with the
//   canonical quiet NaN 32'h7FC00000, one cycle after accept. In that case
//   addsub is not started.
//
// Ports:
//   clk, n_rst                  clock (rising edge), async active-low reset
//   req_valid/req_ready         upstream request handshake
//   req_mode/req_op1/req_op2    request: 0 = add, 1 = subtract; operands
//   add_start                   one-cycle start pulse to addsub
//   mode/op1/op2                registered operation/operands to addsub
//   add_result/add_done         addsub result, valid while add_done = 1
//   add_overflow                addsub overflow flag, valid with add_done
//   rsp_valid/rsp_ready         downstream response handshake
//   rsp_result/rsp_overflow     captured result and overflow
//   rsp_timeout                 response was produced by the watchdog
// ---------------------------------------------------------------------------
module addsub_issuer #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_mode,
    input  logic [DATA_W-1:0] req_op1,
    input  logic [DATA_W-1:0] req_op2,
    output logic              add_start,
    output logic              mode,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    input  logic [DATA_W-1:0] add_result,
    input  logic              add_done,
    input  logic              add_overflow,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_overflow,
    output logic              rsp_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // The counter starts at 0 in the first WAIT cycle and counts completed
    // WAIT cycles. The watchdog fires on the edge where it would reach
    // TIMEOUT_CYCLES-1. This limits WAIT to TIMEOUT_CYCLES-1 cycles, so
    // rsp_valid rises TIMEOUT_CYCLES cycles after the add_start cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

`ifdef FP_NAN_BYPASS_EN
    localparam logic [DATA_W-1:0] QNAN = DATA_W'(32'h7FC0_0000);

    // NaN test on the IEEE-754 single exponent/mantissa fields.
    function automatic logic is_nan(input logic [30:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction
`endif

    state_t            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              add_start_q, add_start_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_overflow_q, rsp_overflow_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bypass_s;

    // Decide whether the request at the input skips addsub (NaN operand).
    always_comb begin
`ifdef FP_NAN_BYPASS_EN
        bypass_s = is_nan(req_op1[30:0]) || is_nan(req_op2[30:0]);
`else
        bypass_s = 1'b0;
`endif
    end

    // Next-state and next-output logic of the issue/wait/response sequence.
    always_comb begin
        state_d        = state_q;
        req_ready_d    = req_ready_q;
        add_start_d    = 1'b0;
        mode_d         = mode_q;
        op1_d          = op1_q;
        op2_d          = op2_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_result_d   = rsp_result_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_timeout_d  = rsp_timeout_q;
        cnt_d          = cnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    mode_d      = req_mode;
                    op1_d       = req_op1;
                    op2_d       = req_op2;
                    if (bypass_s) begin
`ifdef FP_NAN_BYPASS_EN
                        rsp_result_d = QNAN;
`else
                        rsp_result_d = '0;
`endif
                        rsp_overflow_d = 1'b0;
                        rsp_timeout_d  = 1'b0;
                        rsp_valid_d    = 1'b1;
                        state_d        = RESP;
                    end else begin
                        add_start_d = 1'b1;
                        state_d     = ISSUE;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A done on the watchdog cycle still delivers the real result.
                if (add_done) begin
                    rsp_result_d   = add_result;
                    rsp_overflow_d = add_overflow;
                    rsp_timeout_d  = 1'b0;
                    rsp_valid_d    = 1'b1;
                    state_d        = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_result_d   = '0;
                    rsp_overflow_d = 1'b0;
                    rsp_timeout_d  = 1'b1;
                    rsp_valid_d    = 1'b1;
                    state_d        = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            req_ready_q    <= 1'b1;
            add_start_q    <= 1'b0;
            mode_q         <= 1'b0;
            op1_q          <= '0;
            op2_q          <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_result_q   <= '0;
            rsp_overflow_q <= 1'b0;
            rsp_timeout_q  <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            req_ready_q    <= req_ready_d;
            add_start_q    <= add_start_d;
            mode_q         <= mode_d;
            op1_q          <= op1_d;
            op2_q          <= op2_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_result_q   <= rsp_result_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_timeout_q  <= rsp_timeout_d;
            cnt_q          <= cnt_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign add_start    = add_start_q;
    assign mode         = mode_q;
    assign op1          = op1_q;
    assign op2          = op2_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_timeout  = rsp_timeout_q;

endmodule
